if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC register and runs a single-outstanding valid/ready request to instruction memory; tolerates variable memory latency.
- Drives if_instr/if_pc4 into IF/ID; emits a NOP bubble (32'b0) whenever no fetched instruction is ready.
- Handles pipeline stall (hold) and branch/jump redirect (redirect also drives IF/ID flush).

---
 rtl/cpu_pkg.sv | 18 +
 rtl/if_fetch_stage.sv | 100 ++++++++++
 tb/tb_if_fetch_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, bubble encoding and reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem request and
// presents a registered instruction (or NOP bubble) to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [31:0] pc_out
);
    import cpu_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic [31:0]  redirect_tgt;
    logic [31:0]  pc_inc;

    assign redirect_tgt = align_pc(redirect_pc);
    assign pc_inc       = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect) pc_d = redirect_tgt;
                // A request accepted alongside a redirect targets the old PC: squash it.
                if (imem_ready) state_d = redirect ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rvalid ? S_REQ : S_DISCARD;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    pc4_d   = pc_inc;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    instr_d = NOP_INSTR;
                    pc4_d   = 32'd0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    instr_d = NOP_INSTR;
                    pc4_d   = 32'd0;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (redirect) pc_d = redirect_tgt;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    // Outputs decode only registered state, never imem_rdata directly.
    always_comb begin
        imem_req  = (state_q == S_REQ) && !reset;
        imem_addr = pc_q;
        if_valid  = (state_q == S_HOLD);
        if_instr  = if_valid ? instr_q : NOP_INSTR;
        if_pc4    = if_valid ? pc4_q : 32'd0;
        pc_out    = pc_q;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage with a variable-latency memory model.
module tb_if_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [31:0] pc_out;

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_instr    (if_instr),
        .if_pc4      (if_pc4),
        .if_valid    (if_valid),
        .pc_out      (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: fetch target, whether a request is in flight, whether it is stale,
    // and whether an instruction is being presented.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;
    bit          m_hold;
    exp_t        sb_q[$];
    bit          run = 1'b0;

    // Memory environment state.
    bit          mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;
    bit          acc;
    logic [31:0] acc_addr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'hFFFF_FFFC;
            3: return 32'hFFFF_FFF9;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every cycle away from the active edge.
    bit   prev_valid, prev_stall, prev_redirect;
    exp_t cur;
    always @(negedge clk) begin
        if (reset) begin
            chk(imem_req == 1'b0, "rst_imem_req", {31'd0, imem_req}, 32'd0);
            chk(if_valid == 1'b0, "rst_if_valid", {31'd0, if_valid}, 32'd0);
            chk(if_instr == 32'h0, "rst_if_instr", if_instr, 32'h0);
            chk(if_pc4 == 32'h0, "rst_if_pc4", if_pc4, 32'h0);
            chk(pc_out == 32'h0, "rst_pc_out", pc_out, 32'h0);
            prev_valid = 1'b0;
        end else if (run) begin
            chk(if_valid == m_hold, "if_valid", {31'd0, if_valid}, {31'd0, m_hold});
            chk(imem_req == (!m_out && !m_hold), "imem_req", {31'd0, imem_req},
                {31'd0, (!m_out && !m_hold)});
            chk(pc_out == m_pc, "pc_out", pc_out, m_pc);
            if (imem_req && imem_ready) chk(imem_addr == m_pc, "imem_addr", imem_addr, m_pc);
            if (if_valid) begin
                if (!(prev_valid && prev_stall && !prev_redirect)) begin
                    if (sb_q.size() == 0) chk(1'b0, "sb_empty", 32'd0, 32'd1);
                    else cur = sb_q.pop_front();
                end
                chk(if_instr == cur.instr, "if_instr", if_instr, cur.instr);
                chk(if_pc4 == cur.pc4, "if_pc4", if_pc4, cur.pc4);
            end else begin
                chk(if_instr == 32'h0, "bubble_instr", if_instr, 32'h0);
                chk(if_pc4 == 32'h0, "bubble_pc4", if_pc4, 32'h0);
            end
            prev_valid    = if_valid;
            prev_stall    = stall;
            prev_redirect = redirect;
        end
    end

    task automatic model_reset();
        m_pc     = 32'h0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_hold   = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        sb_q.delete();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Apply the architectural rules for the edge that just passed.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (m_hold) begin
            if (redirect) begin
                m_hold = 1'b0;
                m_pc   = tgt;
            end else if (!stall) begin
                m_hold = 1'b0;
                m_pc   = m_pc + 32'd4;
            end
        end else if (m_out) begin
            if (imem_rvalid) begin
                m_out = 1'b0;
                if (!m_stale && !redirect) begin
                    m_hold = 1'b1;
                    sb_q.push_back('{instr: mem_fn(m_pc), pc4: m_pc + 32'd4});
                end
            end
            if (redirect) begin
                m_pc    = tgt;
                m_stale = 1'b1;
            end
        end else if (acc) begin
            m_out   = 1'b1;
            m_stale = redirect;
            if (redirect) m_pc = tgt;
        end else if (redirect) begin
            m_pc = tgt;
        end
        if (imem_rvalid && mem_busy) mem_busy = 1'b0;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = $urandom_range(1, 3);
        end
    endtask

    task automatic drive(input int cyc);
        bit directed;
        directed = (cyc < 24);
        stall       = directed ? 1'b0 : ($urandom_range(0, 9) < 4);
        redirect    = directed ? 1'b0 : ($urandom_range(0, 9) == 0);
        redirect_pc = pick_target();
        imem_ready  = directed ? 1'b1 : ($urandom_range(0, 9) < 6);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_fn(mem_addr);
            end
        end else if ($urandom_range(0, 19) == 0) begin
            imem_rvalid = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc      = imem_req && imem_ready;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            model_step();
            if (cyc == 1500) begin
                reset = 1'b1;
                model_reset();
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
            end else begin
                drive(cyc);
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
